bcd_converter_seq: RTL and testbench
====================================

// Module: bcd_converter_seq
// PURPOSE
//  Sequential binary-to-BCD converter: shift-and-add-3 (double dabble), one input bit per enabled cycle.
//  Successor to the combinational double_dabble_top_generic.
//  Adds valid/ready handshakes on both sides, optional signed (two's complement) input and a
//  leading-zero digit mask. Used by display/UART formatting paths where area beats latency.
// PARAMETERS
//  Input_Bit_Width      16  binary input width; minimum 4
//  Signed_Mode          0   1: bin is two's complement; magnitude is converted and sign is reported
//  Blank_Leading_Zeros  1   1: nibbles_valid masks leading-zero digits; 0: nibbles_valid all ones
//  Total_Nibbles        (Input_Bit_Width/3)+1  derived localparam, not overridable
// PORTS
//  clk            in   1                  clock, rising edge
//  clk_en         in   1                  global enable; low freezes all state and blocks transfers
//  sync_rst_n     in   1                  synchronous reset, active low
//  bin            in   Input_Bit_Width    binary value to convert
//  bin_valid      in   1                  bin is presented
//  bin_ready      out  1                  converter can accept bin
//  nibbles_out    out  Total_Nibbles*4    packed [Total_Nibbles-1:0][3:0] BCD digits; [0] = ones
//  nibbles_valid  out  Total_Nibbles      per-digit significance mask
//  negative       out  1                  result sign; always 0 when Signed_Mode=0
//  out_valid      out  1                  result is held on outputs
//  out_ready      in   1                  consumer accepts result
// BEHAVIOUR
//  Transfers:
//   in_xfer  = bin_valid & bin_ready & clk_en
//   out_xfer = out_valid & out_ready & clk_en
//  With clk_en low: no register changes; ready/valid remain driven from current state.
//  Reset (sync_rst_n=0 at clk edge, regardless of clk_en) -> state IDLE.
//   Outputs after reset: bin_ready=1, out_valid=0, nibbles_out=0, nibbles_valid=0, negative=0.
//  FSM:
//   IDLE  bin_ready=1; on in_xfer:
//         - latch magnitude into shift reg (Signed_Mode & bin MSB ? -bin : bin, W-bit unsigned);
//         - latch sign; clear BCD accumulator; load bit counter = Input_Bit_Width;
//         - go SHIFT.
//   SHIFT per enabled cycle: every BCD nibble >=5 gets +3, then {bcd,shreg} shifts left 1.
//         Counter decrements; at the enabled cycle where counter reaches 0, go DONE.
//   DONE  out_valid=1; outputs stable while out_valid=1 and out_ready=0.
//         On out_xfer: go IDLE, unless in_xfer in same cycle, then go SHIFT directly.
//  bin_ready = (state==IDLE) | (state==DONE & out_ready): back-to-back with no bubble.
//  Latency: DONE/out_valid asserted exactly Input_Bit_Width enabled cycles after in_xfer.
//   Throughput: one result per Input_Bit_Width+1 enabled cycles.
//  Signed: -2^(W-1) converts as magnitude 2^(W-1) with negative=1; -0 cannot occur.
//   Zero result always has negative=0.
//  nibbles_valid (Blank_Leading_Zeros=1): bit i=1 iff i <= index of most-significant nonzero digit.
//   Bit 0 is always 1, so zero shows a single "0".
//  nibbles_out, nibbles_valid and negative are registered.
//   Updated only on entry to DONE; held through IDLE until the next DONE.
//  Reset mid-SHIFT or mid-DONE: conversion discarded, no out_valid pulse, returns IDLE next cycle.
//  bin changes while not transferred: ignored.
//  Unused top-nibble capacity must read 0.
// TESTING
//  W=8 unsigned, bin=255 -> out_valid after 8 enabled cycles.
//   Nibbles {2,5,5}, nibbles_valid=3'b111, negative=0.
//  W=8, bin=0 -> nibbles {0,0,0}, nibbles_valid=3'b001.
//   bin=7 -> {0,0,7}, mask 3'b001; bin=40 -> {0,4,0}, mask 3'b011.
//  W=8 Signed_Mode=1, bin=8'h80 -> negative=1, {1,2,8}.
//   bin=8'hFF -> negative=1, {0,0,1}; bin=8'h7F -> negative=0, {1,2,7}.
//  clk_en toggling 1010... during SHIFT, bin=200 -> out_valid after 16 clocks.
//   Result {2,0,0}; no state change on clk_en=0 cycles.
//  Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, bin_ready=0.
//   Then out_ready=1 with bin_valid=1 -> new SHIFT starts that same edge.
//  Reset mid-SHIFT (after 3 bits) -> next cycle bin_ready=1, out_valid=0.
//   A following bin=99 converts cleanly to {0,9,9}.
//  Sweep 0..2^W-1, W=8 and W=10 -> every result matches the reference model digit-for-digit.

Source files
------------

// File: rtl/bcd_converter_seq_if.sv
// bcd_converter_seq_if: input/result handshake bundle for the sequential BCD converter.
interface bcd_converter_seq_if #(
    parameter int W = 16
);
    localparam int N = W / 3 + 1;
    logic [W-1:0]      bin;
    logic              bin_valid;
    logic              bin_ready;
    logic [N-1:0][3:0] nibbles_out;
    logic [N-1:0]      nibbles_valid;
    logic              negative;
    logic              out_valid;
    logic              out_ready;
    modport master (
        output bin, bin_valid, out_ready,
        input  bin_ready, nibbles_out, nibbles_valid, negative, out_valid
    );
    modport slave (
        input  bin, bin_valid, out_ready,
        output bin_ready, nibbles_out, nibbles_valid, negative, out_valid
    );
endinterface

// File: rtl/bcd_converter_seq.sv
// bcd_converter_seq: double-dabble binary-to-BCD converter, one bit per enabled cycle,
// with valid/ready on both sides, optional signed input and leading-zero digit mask.
module bcd_converter_seq #(
    parameter int Input_Bit_Width     = 16,
    parameter int Signed_Mode         = 0,
    parameter int Blank_Leading_Zeros = 1
) (
    input  logic                 clk,
    input  logic                 clk_en,
    input  logic                 sync_rst_n,
    bcd_converter_seq_if.slave   bus
);
    localparam int W             = Input_Bit_Width;
    localparam int Total_Nibbles = W / 3 + 1;
    localparam int N             = Total_Nibbles;
    localparam int CW            = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   shreg_q, shreg_d, shreg_sh, mag;
    logic [4*N-1:0] bcd_q, bcd_d, bcd_adj, bcd_sh, nib_q, nib_d;
    logic [N-1:0]   mask_q, mask_d, mask_sh;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sign_q, sign_d, neg_q, neg_d, in_xfer, out_xfer, seen;

    assign bus.bin_ready     = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
    assign bus.out_valid     = (state_q == DONE);
    assign bus.nibbles_out   = nib_q;
    assign bus.nibbles_valid = mask_q;
    assign bus.negative      = neg_q;

    always_comb begin
        in_xfer  = bus.bin_valid & bus.bin_ready & clk_en;
        out_xfer = bus.out_valid & bus.out_ready & clk_en;
        mag      = (Signed_Mode != 0 && bus.bin[W-1]) ? -bus.bin : bus.bin;
        bcd_adj  = bcd_q;
        for (int i = 0; i < N; i++)
            bcd_adj[4*i+:4] = (bcd_q[4*i+:4] >= 4'd5) ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
        {bcd_sh, shreg_sh} = {bcd_adj, shreg_q} << 1;
        // Mask keeps every digit at or below the most significant nonzero one
        seen    = 1'b0;
        mask_sh = '0;
        for (int i = N - 1; i >= 0; i--) begin
            seen       = seen | (|bcd_sh[4*i+:4]);
            mask_sh[i] = seen || i == 0 || Blank_Leading_Zeros == 0;
        end
        state_d = state_q;
        shreg_d = shreg_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        nib_d   = nib_q;
        mask_d  = mask_q;
        neg_d   = neg_q;
        if (state_q == SHIFT) begin
            shreg_d = shreg_sh;
            bcd_d   = bcd_sh;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = DONE;
                nib_d   = bcd_sh;
                mask_d  = mask_sh;
                neg_d   = sign_q && (|bcd_sh);
            end
        end
        if (out_xfer) state_d = IDLE;
        if (in_xfer) begin
            state_d = SHIFT;
            shreg_d = mag;
            sign_d  = Signed_Mode != 0 && bus.bin[W-1];
            bcd_d   = '0;
            cnt_d   = CW'(W);
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            nib_q   <= '0;
            mask_q  <= '0;
            neg_q   <= 1'b0;
        end else if (clk_en) begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            nib_q   <= nib_d;
            mask_q  <= mask_d;
            neg_q   <= neg_d;
        end
    end
endmodule

// File: tb/tb_bcd_converter_seq.sv
// tb_bcd_converter_seq: directed vectors and full sweeps for the sequential BCD converter
module tb_bcd_converter_seq;
  logic       clk = 1'b0;
  logic       clk_en, rst_n;
  logic [7:0] b8;
  logic       v8, r8;
  logic [9:0] b10;
  logic       v10, r10;
  int         cyc, n_cmp, n_err;
  logic       ok_bp;
  always #5 clk = ~clk;
  bcd_converter_seq_if #(.W(8))  if8u ();
  bcd_converter_seq_if #(.W(8))  if8s ();
  bcd_converter_seq_if #(.W(10)) if10 ();
  assign if8u.bin = b8;   assign if8u.bin_valid = v8;  assign if8u.out_ready = r8;
  assign if8s.bin = b8;   assign if8s.bin_valid = v8;  assign if8s.out_ready = r8;
  assign if10.bin = b10;  assign if10.bin_valid = v10; assign if10.out_ready = r10;
  bcd_converter_seq #(.Input_Bit_Width(8), .Signed_Mode(0), .Blank_Leading_Zeros(1)) u_u8 (
    .clk(clk), .clk_en(clk_en), .sync_rst_n(rst_n), .bus(if8u));
  bcd_converter_seq #(.Input_Bit_Width(8), .Signed_Mode(1), .Blank_Leading_Zeros(1)) u_s8 (
    .clk(clk), .clk_en(clk_en), .sync_rst_n(rst_n), .bus(if8s));
  bcd_converter_seq #(.Input_Bit_Width(10), .Signed_Mode(0), .Blank_Leading_Zeros(0)) u_u10 (
    .clk(clk), .clk_en(clk_en), .sync_rst_n(rst_n), .bus(if10));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] bcd_of(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  function automatic logic [3:0] mask_of(input logic [15:0] d);
    int top;
    top = 0;
    for (int i = 0; i < 4; i++) if (d[4*i+:4] != 4'd0) top = i;
    return 4'((2 << top) - 1);
  endfunction
  task automatic wait8();
    cyc = 0;
    while (if8u.out_valid !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    chk("wait8_expired", if8u.out_valid, 1'b1);
  endtask
  task automatic run8(input logic [7:0] v);
    b8 = v; v8 = 1'b1; r8 = 1'b0;
    @(negedge clk);
    v8 = 1'b0;
    wait8();
  endtask
  task automatic ack8();
    r8 = 1'b1;
    @(negedge clk);
    r8 = 1'b0;
  endtask
  task automatic run10(input logic [9:0] v);
    b10 = v; v10 = 1'b1; r10 = 1'b0;
    @(negedge clk);
    v10 = 1'b0;
    cyc = 0;
    while (if10.out_valid !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    chk("wait10_expired", if10.out_valid, 1'b1);
  endtask
  initial begin
    logic [15:0] d;
    logic [7:0]  m;
    n_cmp = 0; n_err = 0;
    clk_en = 1'b1; rst_n = 1'b0;
    b8 = '0; v8 = 1'b0; r8 = 1'b0; b10 = '0; v10 = 1'b0; r10 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_bin_ready", if8u.bin_ready, 1'b1);
    chk("rst_out_valid", if8u.out_valid, 1'b0);
    chk("rst_nibbles", if8u.nibbles_out, 12'h000);
    chk("rst_mask", if8u.nibbles_valid, 3'b000);
    chk("rst_negative", if8s.negative, 1'b0);
    run8(8'd255);
    chk("lat_255", cyc, 8);
    chk("u255", {if8u.negative, if8u.nibbles_valid, if8u.nibbles_out}, {1'b0, 3'b111, 12'h255});
    chk("sFF", {if8s.negative, if8s.nibbles_valid, if8s.nibbles_out}, {1'b1, 3'b001, 12'h001});
    ack8();
    chk("idle_after_ack", if8u.out_valid, 1'b0);
    chk("held_in_idle", if8u.nibbles_out, 12'h255);
    run8(8'd0);
    chk("u0", {if8u.negative, if8u.nibbles_valid, if8u.nibbles_out}, {1'b0, 3'b001, 12'h000});
    chk("s0", {if8s.negative, if8s.nibbles_valid, if8s.nibbles_out}, {1'b0, 3'b001, 12'h000});
    ack8();
    run8(8'd7);
    chk("u7", {if8u.nibbles_valid, if8u.nibbles_out}, {3'b001, 12'h007});
    ack8();
    run8(8'd40);
    chk("u40", {if8u.nibbles_valid, if8u.nibbles_out}, {3'b011, 12'h040});
    ack8();
    run8(8'h80);
    chk("u128", {if8u.negative, if8u.nibbles_valid, if8u.nibbles_out}, {1'b0, 3'b111, 12'h128});
    chk("s80", {if8s.negative, if8s.nibbles_valid, if8s.nibbles_out}, {1'b1, 3'b111, 12'h128});
    ack8();
    run8(8'h7F);
    chk("s7F", {if8s.negative, if8s.nibbles_valid, if8s.nibbles_out}, {1'b0, 3'b111, 12'h127});
    ack8();
    b8 = 8'd200; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      clk_en = (k % 2 == 0);
      @(negedge clk);
      if (k == 15) chk("gated_not_done", if8u.out_valid, 1'b0);
    end
    chk("gated_done", if8u.out_valid, 1'b1);
    chk("gated_200", if8u.nibbles_out, 12'h200);
    clk_en = 1'b0; r8 = 1'b1;
    @(negedge clk);
    chk("frozen_done", if8u.out_valid, 1'b1);
    clk_en = 1'b1;
    @(negedge clk);
    r8 = 1'b0;
    chk("unfrozen_ack", if8u.out_valid, 1'b0);
    run8(8'd123);
    ok_bp = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ok_bp = ok_bp & (if8u.out_valid === 1'b1) & (if8u.bin_ready === 1'b0)
              & (if8u.nibbles_out === 12'h123);
      @(negedge clk);
    end
    chk("bp_stable", ok_bp, 1'b1);
    b8 = 8'd99; v8 = 1'b1; r8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0; r8 = 1'b0;
    chk("b2b_out_valid", if8u.out_valid, 1'b0);
    chk("b2b_bin_ready", if8u.bin_ready, 1'b0);
    chk("b2b_held", if8u.nibbles_out, 12'h123);
    wait8();
    chk("b2b_lat", cyc, 8);
    chk("b2b_99", {if8u.nibbles_valid, if8u.nibbles_out}, {3'b011, 12'h099});
    ack8();
    b8 = 8'd50; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_bin_ready", if8u.bin_ready, 1'b1);
    chk("midrst_out_valid", if8u.out_valid, 1'b0);
    run8(8'd99);
    chk("midrst_lat", cyc, 8);
    chk("midrst_99", {if8u.nibbles_valid, if8u.nibbles_out}, {3'b011, 12'h099});
    ack8();
    for (int v = 0; v < 256; v++) begin
      run8(8'(v));
      d = bcd_of(v);
      chk("sweep_u8", {if8u.negative, if8u.nibbles_valid, if8u.nibbles_out},
          {1'b0, mask_of(d)[2:0], d[11:0]});
      m = (v >= 128) ? 8'(256 - v) : 8'(v);
      d = bcd_of(int'(m));
      chk("sweep_s8", {if8s.negative, if8s.nibbles_valid, if8s.nibbles_out},
          {v >= 128, mask_of(d)[2:0], d[11:0]});
      ack8();
    end
    for (int v = 0; v < 1024; v++) begin
      run10(10'(v));
      d = bcd_of(v);
      chk("sweep_u10", {cyc[3:0], if10.negative, if10.nibbles_valid, if10.nibbles_out},
          {4'd10, 1'b0, 4'b1111, d});
      r10 = 1'b1;
      @(negedge clk);
      r10 = 1'b0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
